// File: rtl/alpha_rank_datapath.sv
`default_nettype none
// ============================================================================
// Module      : alpha_rank_datapath
// Description : Per-sample difference engine for the alphabet-ranking stage.
//               A free-running sample counter, a registered X-Y-Bin
//               subtractor, a 64-entry difference memory written at the
//               sample's counter value, and a running minimum tracker that
//               reports the address of the smallest stored difference.
//               Optional build macro: DIFF_CLAMP_EN (borrowing results are
//               stored and reported as zero).
// Revision    : 1.0 - initial release
// ============================================================================
module alpha_rank_datapath #(
    parameter int WIDTH = 12,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DE,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    input  logic             CS,
    input  logic [AW-1:0]    RD_ADDR,
    output logic [AW-1:0]    COUNT,
    output logic             OE,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout,
    output logic [WIDTH-1:0] DIFF_OUT,
    output logic [AW-1:0]    ADDR_OUT
);

    // Subtraction is carried at WIDTH+1 bits so the top bit is the borrow.
    logic [WIDTH:0]   w_sub_full;
    logic             w_borrow;
    logic [WIDTH-1:0] w_diff;

    // Write pipeline: aligns the sample's counter value with its difference.
    logic [AW-1:0]    r_cnt_d1;
    logic [AW-1:0]    r_cnt_d2;
    logic [WIDTH-1:0] r_diff_d;
    logic             r_rw_n;

    // Ranking state.
    logic [WIDTH-1:0] r_min;
    logic             r_min_valid;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_new_min;

    assign w_sub_full = {1'b0, X} - {1'b0, Y} - {{WIDTH{1'b0}}, Bin};
    assign w_borrow   = w_sub_full[WIDTH];

`ifdef DIFF_CLAMP_EN
    assign w_diff = w_borrow ? '0 : w_sub_full[WIDTH-1:0];
`else
    assign w_diff = w_sub_full[WIDTH-1:0];
`endif

    // rw_n picks exactly one of write or read, so they never collide.
    assign w_wr_en   = CS && !r_rw_n;
    assign w_rd_en   = CS &&  r_rw_n;
    // Strict compare keeps the earlier address on ties.
    assign w_new_min = !r_min_valid || (r_diff_d < r_min);

    // Free-running sample counter, wraps naturally at 2**AW.
    always_ff @(posedge CLK) begin
        if (RST) begin
            COUNT <= '0;
        end else begin
            COUNT <= COUNT + 1'b1;
        end
    end

    // Registered subtractor; result and borrow hold while DE is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DIFF <= '0;
            Bout <= 1'b0;
            OE   <= 1'b1;
        end else if (!DE) begin
            DIFF <= w_diff;
            Bout <= w_borrow;
            OE   <= 1'b0;
        end else begin
            OE   <= 1'b1;
        end
    end

    // Write pipeline; reset forces rw_n high so in-flight samples are dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt_d1 <= '0;
            r_cnt_d2 <= '0;
            r_diff_d <= '0;
            r_rw_n   <= 1'b1;
        end else begin
            r_cnt_d1 <= COUNT;
            r_cnt_d2 <= r_cnt_d1;
            r_diff_d <= DIFF;
            r_rw_n   <= OE;
        end
    end

    // Difference memory array; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (!RST && w_wr_en) begin
            r_mem[r_cnt_d2] <= r_diff_d;
        end
    end

    // Registered read port; holds when deselected or writing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DIFF_OUT <= '0;
        end else if (w_rd_en) begin
            DIFF_OUT <= r_mem[RD_ADDR];
        end
    end

    // Running minimum over performed writes; no re-scan on overwrite.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_min       <= '0;
            r_min_valid <= 1'b0;
            ADDR_OUT    <= '0;
        end else if (w_wr_en && w_new_min) begin
            r_min       <= r_diff_d;
            r_min_valid <= 1'b1;
            ADDR_OUT    <= r_cnt_d2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alpha_rank_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_alpha_rank_datapath
// Description : Self-checking bench for alpha_rank_datapath: vector table for
//               the subtractor plus directed sequences for counter wrap,
//               memory write/read, chip select and ranking with reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alpha_rank_datapath;

    localparam int WIDTH = 12;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic             CLK = 1'b0;
    logic             RST, DE, Bin, CS;
    logic [WIDTH-1:0] X, Y;
    logic [AW-1:0]    RD_ADDR;
    logic [AW-1:0]    COUNT, ADDR_OUT;
    logic             OE, Bout;
    logic [WIDTH-1:0] DIFF, DIFF_OUT;

    int n_checks = 0;
    int n_errors = 0;

    alpha_rank_datapath #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .DE(DE), .X(X), .Y(Y), .Bin(Bin), .CS(CS),
        .RD_ADDR(RD_ADDR), .COUNT(COUNT), .OE(OE), .DIFF(DIFF), .Bout(Bout),
        .DIFF_OUT(DIFF_OUT), .ADDR_OUT(ADDR_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             bin;
        logic [WIDTH-1:0] raw_diff;
        logic             bout;
    } sub_vec_t;

    sub_vec_t vecs [6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic sample(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
        DE = 1'b0; X = xv; Y = yv; Bin = 1'b0;
        tick();
        DE = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_d;

        RST = 1'b1; DE = 1'b1; X = '0; Y = '0; Bin = 1'b0; CS = 1'b0; RD_ADDR = '0;

        // Hand-computed raw (unclamped) results.
        vecs[0] = '{12'd2,   12'd1,   1'b0, 12'h001, 1'b0};
        vecs[1] = '{12'd1,   12'd2,   1'b0, 12'hFFF, 1'b1};
        vecs[2] = '{12'd5,   12'd5,   1'b1, 12'hFFF, 1'b1};
        vecs[3] = '{12'hFFF, 12'h000, 1'b1, 12'hFFE, 1'b0};
        vecs[4] = '{12'h000, 12'hFFF, 1'b0, 12'h001, 1'b1};
        vecs[5] = '{12'd100, 12'd37,  1'b0, 12'h03F, 1'b0};

        // Reset state
        tick();
        RST = 1'b0;
        chk("rst_count",    32'(COUNT),    32'd0);
        chk("rst_diff",     32'(DIFF),     32'd0);
        chk("rst_bout",     32'(Bout),     32'd0);
        chk("rst_oe",       32'(OE),       32'd1);
        chk("rst_diff_out", 32'(DIFF_OUT), 32'd0);
        chk("rst_addr_out", 32'(ADDR_OUT), 32'd0);

        // Subtractor vector table (CS=0, so memory and ranking untouched)
        for (int i = 0; i < 6; i++) begin
            DE = 1'b0; X = vecs[i].x; Y = vecs[i].y; Bin = vecs[i].bin;
            tick();
            exp_d = vecs[i].raw_diff;
`ifdef DIFF_CLAMP_EN
            if (vecs[i].bout) exp_d = '0;
`endif
            chk("sub_diff", 32'(DIFF), 32'(exp_d));
            chk("sub_bout", 32'(Bout), 32'(vecs[i].bout));
            chk("sub_oe",   32'(OE),   32'd0);
        end
        // DE high: OE rises, result holds
        DE = 1'b1; X = 12'd7; Y = 12'd1;
        tick();
        chk("hold_oe",   32'(OE),   32'd1);
        chk("hold_diff", 32'(DIFF), 32'h03F);
        chk("hold_bout", 32'(Bout), 32'd0);

        // Counter: 63 then wrap to 0
        do_reset();
        for (int i = 0; i < 63; i++) tick();
        chk("count_63",   32'(COUNT), 32'd63);
        tick();
        chk("count_wrap", 32'(COUNT), 32'd0);

        // Memory write at COUNT=3, then read
        do_reset();
        tick(); tick(); tick();
        chk("count_3", 32'(COUNT), 32'd3);
        CS = 1'b1; RD_ADDR = 6'd3;
        sample(12'd10, 12'd4);           // edge with COUNT=3
        tick();
        tick();                          // third edge: write mem[3]
        chk("mem_rank_addr", 32'(ADDR_OUT), 32'd3);
        tick();
        chk("mem_read_3", 32'(DIFF_OUT), 32'd6);

        // CS=0: write suppressed, DIFF_OUT holds
        CS = 1'b0;
        sample(12'd20, 12'd4);
        tick(); tick(); tick();
        chk("cs0_hold", 32'(DIFF_OUT), 32'd6);
        CS = 1'b1;
        tick();
        chk("cs0_mem_unchanged", 32'(DIFF_OUT), 32'd6);
        chk("cs0_rank_unchanged", 32'(ADDR_OUT), 32'd3);

        // Ranking: samples at COUNT=1..4 with 9,4,7,4
        do_reset();
        tick();
        DE = 1'b0; Y = '0; Bin = 1'b0;
        X = 12'd9; tick();
        X = 12'd4; tick();
        X = 12'd7; tick();
        X = 12'd4; tick();
        DE = 1'b1;
        tick(); tick();
        chk("rank_first_min", 32'(ADDR_OUT), 32'd2);

        // Mid-stream reset drops in-flight sample and clears ranking
        sample(12'd1, 12'd0);
        do_reset();
        chk("mid_rst_addr",  32'(ADDR_OUT), 32'd0);
        chk("mid_rst_oe",    32'(OE),       32'd1);
        chk("mid_rst_count", 32'(COUNT),    32'd0);
        tick(); tick(); tick(); tick();
        sample(12'd50, 12'd0);           // COUNT=4 -> address 4
        tick(); tick();
        chk("post_rst_first", 32'(ADDR_OUT), 32'd4);
        sample(12'd60, 12'd0);           // COUNT=7, larger: no change
        tick(); tick();
        chk("larger_keeps", 32'(ADDR_OUT), 32'd4);
        sample(12'd10, 12'd0);           // COUNT=10, smaller: moves
        tick(); tick();
        chk("smaller_moves", 32'(ADDR_OUT), 32'd10);
        RD_ADDR = 6'd4;
        tick();
        chk("read_addr4", 32'(DIFF_OUT), 32'd50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
